// File: rtl/mod_mult_serial.sv
// Bit-serial interleaved modular multiplier: product = (a * b) mod m.
// One multiplier bit per clock, MSB first. An operation takes N = 2*WIDTH clocks.
module mod_mult_serial #(
    parameter int WIDTH = 128,
    localparam int N = 2 * WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    output logic         busy,
    output logic         finish,
    output logic [N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_m;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_r;
    logic [N-1:0]  r_product;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic          w_last;
    logic [N:0]    w_m_ext;
    logic [N:0]    w_t;
    logic [N:0]    w_t_red;
    logic [N:0]    w_u;
    logic [N:0]    w_u_red;
    logic [N-1:0]  w_r_next;

    // Intermediates are N+1 bits so 2*r and t+a never overflow for any valid m.
    // With m = 0 the subtraction removes nothing and truncation to N bits gives mod 2^N.
    always_comb begin
        w_m_ext = {1'b0, r_m};
        w_t     = {r_r, 1'b0};
        w_t_red = (w_t >= w_m_ext) ? (w_t - w_m_ext) : w_t;
        w_u     = w_t_red + {1'b0, r_a};
        if (r_b_sh[N-1]) begin
            w_u_red = (w_u >= w_m_ext) ? (w_u - w_m_ext) : w_u;
        end else begin
            w_u_red = w_t_red;
        end
        w_r_next = w_u_red[N-1:0];
    end

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_count == CW'(1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        finish       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                finish       = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_m       <= '0;
            r_b_sh    <= '0;
            r_r       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_m     <= m;
            r_b_sh  <= b;
            r_r     <= '0;
            r_count <= CW'(N);
        end else if (r_state == S_RUN) begin
            r_r     <= w_r_next;
            r_b_sh  <= r_b_sh << 1;
            r_count <= r_count - CW'(1);
            // The result register changes only on the final iteration.
            if (w_last) r_product <= w_r_next;
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mod_mult_serial.sv
// Self-checking bench for mod_mult_serial: directed and random operations, with
// expected products queued at launch and compared when finish is observed.
module tb_mod_mult_serial;

    localparam int WIDTH = 128;
    localparam int N     = 2 * WIDTH;
    localparam int LIMIT = N + 20;

    typedef logic [N-1:0] word_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    word_t a;
    word_t b;
    word_t m;
    logic  busy;
    logic  finish;
    word_t product;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    always #5 clk = ~clk;

    mod_mult_serial #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .m       (m),
        .busy    (busy),
        .finish  (finish),
        .product (product)
    );

    task automatic check(input string tag, input word_t obs, input word_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference product computed with a full-width multiply and modulo.
    function automatic word_t golden(input word_t x, input word_t y, input word_t md);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        if (md == '0) return p[N-1:0];
        p = p % {{N{1'b0}}, md};
        return p[N-1:0];
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int k = 0; k < N / 32; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    // Drives a request at posedge+1 and returns at 1 time unit after the accepting edge.
    task automatic launch(input word_t x, input word_t y, input word_t md,
                          input word_t expv, input bit expect_result);
        a     = x;
        b     = y;
        m     = md;
        start = 1'b1;
        if (expect_result) exp_q.push_back(expv);
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until finish; optionally pokes start mid-run.
    task automatic wait_finish(input string tag, input int poke_at,
                               output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!finish && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == poke_at) begin
                start = 1'b1;
                a     = 2;
                b     = 2;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            if (!finish && busy) busy_cnt++;
        end
        check({tag, " finish seen"}, word_t'(finish), word_t'(1));
    endtask

    task automatic check_result(input string tag);
        word_t e;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fails++;
            $error("FAIL %s: observed empty scoreboard expected a queued result", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " product"}, product, e);
        end
    endtask

    task automatic run_op(input string tag, input word_t x, input word_t y,
                          input word_t md, input word_t expv);
        int lat;
        int bc;
        launch(x, y, md, expv, 1'b1);
        start = 1'b0;
        wait_finish(tag, -1, lat, bc);
        check({tag, " latency"}, word_t'(lat), word_t'(N));
        check_result(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    lat;
        int    bc;
        int    lat2;
        int    hold_bad;
        int    pulses;
        word_t m2;
        word_t m3;
        word_t x;
        word_t y;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        m     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", word_t'(busy), word_t'(0));
        check("reset finish", word_t'(finish), word_t'(0));
        check("reset product", product, word_t'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: small operands, exact latency and busy duration.
        launch(3, 5, 7, 1, 1'b1);
        start = 1'b0;
        wait_finish("t1", -1, lat, bc);
        check("t1 latency", word_t'(lat), word_t'(N));
        check("t1 busy cycles", word_t'(bc), word_t'(N));
        check("t1 busy low at finish", word_t'(busy), word_t'(0));
        check_result("t1");
        @(posedge clk);
        #1;
        check("t1 finish one cycle", word_t'(finish), word_t'(0));
        check("t1 idle busy", word_t'(busy), word_t'(0));

        // 2: largest operands, reduction on every iteration; zero operands.
        m2 = '0 - word_t'(189);
        run_op("t2 max", m2 - 1, m2 - 1, m2, 1);
        run_op("t2 a zero", 0, m2 - 1, m2, 0);
        run_op("t2 b zero", m2 - 1, 0, m2, 0);
        run_op("t2 m one", 0, 0, 1, 0);
        run_op("t2 m zero", '1, '1, 0, 1);
        run_op("t2 m zero golden", m2 - 5, m2 - 7, 0, golden(m2 - 5, m2 - 7, 0));

        // 3: fixed vector and random operands against the reference.
        m3 = (word_t'(1) << 255) + word_t'(95);
        x  = word_t'(64'd113680897410347);
        y  = word_t'(64'd7999808077) * word_t'(64'd1000000000000) + word_t'(64'd935876437321);
        run_op("t3 vector", x, y, m3, golden(x, y, m3));
        for (int i = 0; i < 100; i++) begin
            x = rand_word() % m3;
            y = rand_word() % m3;
            run_op("t3 random", x, y, m3, golden(x, y, m3));
        end

        // 4: a second start while running is ignored.
        launch(3, 5, 7, 1, 1'b1);
        start = 1'b0;
        wait_finish("t4", 100, lat, bc);
        check("t4 latency", word_t'(lat), word_t'(N));
        check_result("t4");
        @(posedge clk);
        #1;
        check("t4 no restart", word_t'(busy), word_t'(0));

        // 5: start held through DONE; inputs changed after acceptance.
        launch(3, 5, 7, 1, 1'b1);
        a = 4;
        b = 6;
        exp_q.push_back(3);
        wait_finish("t5a", -1, lat, bc);
        check("t5a latency", word_t'(lat), word_t'(N));
        check_result("t5a");
        lat2     = 0;
        hold_bad = 0;
        do begin
            @(posedge clk);
            #1;
            lat2++;
            if (lat2 == 1) begin
                check("t5 accepted on finish cycle", word_t'(busy), word_t'(1));
                start = 1'b0;
            end
            if (!finish && product !== word_t'(1)) hold_bad++;
        end while (!finish && lat2 < LIMIT);
        check("t5 second latency", word_t'(lat2), word_t'(N + 1));
        check("t5 product held", word_t'(hold_bad), word_t'(0));
        check_result("t5b");

        // 6: reset mid-run, together with start; no finish afterwards.
        launch(2, 2, 7, 0, 1'b0);
        start = 1'b0;
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        start = 1'b1;
        #1;
        check("t6 busy on reset", word_t'(busy), word_t'(0));
        check("t6 finish on reset", word_t'(finish), word_t'(0));
        check("t6 product on reset", product, word_t'(0));
        @(posedge clk);
        #1;
        check("t6 reset wins over start", word_t'(busy), word_t'(0));
        start = 1'b0;
        reset = 1'b0;
        pulses = 0;
        repeat (LIMIT) begin
            @(posedge clk);
            #1;
            if (finish) pulses++;
        end
        check("t6 no finish pulse", word_t'(pulses), word_t'(0));
        run_op("t6 after reset", 3, 5, 7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
